seq_alu: RTL and testbench

- Parametrised, registered successor to the datapath ALU. Single-cycle logic, shift, rotate and add ops; iterative multi-cycle signed multiply and divide.
- Operands are latched on a start/done handshake. Results are held in internal HI/LO result registers until the next accepted start.
- Sits between the register-file read ports and the Z/HI/LO capture logic. The control sequencer pulses start and waits for done.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/seq_muldiv_core.sv | 85 ++++++++
 rtl/seq_alu.sv | 179 +++++++++++++++++
 tb/tb_seq_alu.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Op codes and sequencer state encoding shared by seq_alu and its mul/div core.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_SHR  = 5'd5;
    localparam logic [4:0] OP_SHRA = 5'd6;
    localparam logic [4:0] OP_SHL  = 5'd7;
    localparam logic [4:0] OP_ROR  = 5'd8;
    localparam logic [4:0] OP_ROL  = 5'd9;
    localparam logic [4:0] OP_AND  = 5'd10;
    localparam logic [4:0] OP_OR   = 5'd11;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ITER = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative signed mul/div on magnitudes: one shift-add or restoring step per 'step',
// WIDTH steps after 'load'; res_hi/res_lo carry the sign-corrected result combinationally.
module seq_muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, mb_q;
    logic [CW-1:0]      cnt_q;
    logic               div_q, neg_q, neg_a_q;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum, shifted, diff;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        mag_a = a[WIDTH-1] ? -a : a;
        mag_b = b[WIDTH-1] ? -b : b;
    end

    // hi holds the product high half / partial remainder, lo the multiplier / quotient bits
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mb_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, mb_q};
        if (div_q) begin
            if (!diff[WIDTH]) begin
                hi_d = diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = shifted[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod   = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (div_q) begin
            res_lo = neg_q   ? -lo_q : lo_q;
            res_hi = neg_a_q ? -hi_q : hi_q;
        end
        last = step && (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi_q    <= '0;
            lo_q    <= '0;
            mb_q    <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            neg_a_q <= 1'b0;
        end else if (load) begin
            hi_q    <= '0;
            lo_q    <= mag_a;
            mb_q    <= mag_b;
            cnt_q   <= '0;
            div_q   <= is_div;
            neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_a_q <= a[WIDTH-1];
        end else if (step) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU: single-cycle ops done at N+1, mul/div done at N+WIDTH+2; start ignored while busy.
// SEQ_ALU_FLAGS_EN adds registered zero/negative/carry outputs updated with done.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
`ifdef SEQ_ALU_FLAGS_EN
    output logic             zero,
    output logic             negative,
    output logic             carry,
`endif
    output logic             div_by_zero
);
`ifdef SEQ_ALU_FLAGS_EN
    localparam int AW = WIDTH + 1;
    logic alu_carry, zero_q, zero_d, neg_q, neg_d, carry_q, carry_d;
`else
    localparam int AW = WIDTH;
`endif

    state_t           state_q, state_d;
    logic             accept, iter_op, core_load, core_step, core_last;
    logic [WIDTH-1:0] core_hi, core_lo, alu_hi, alu_lo, sra, rot_r, rot_l;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d, dbz_q, dbz_d, alu_dbz, big, sub;
    logic [SHW-1:0]   amt;
    logic [AW-1:0]    add_sum;

    seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (core_load),
        .step    (core_step),
        .is_div  (op == OP_DIV),
        .a       (A),
        .b       (B),
        .last    (core_last),
        .res_hi  (core_hi),
        .res_lo  (core_lo)
    );

    // Single-cycle results are computed from the live inputs and captured on the accepting edge
    always_comb begin
        amt     = B[SHW-1:0];
        big     = (B >> SHW) != '0;
        sub     = (op == OP_SUB);
        add_sum = AW'(A) + AW'(sub ? ~B : B) + AW'(sub);
        sra     = $signed(A) >>> amt;
        rot_r   = WIDTH'({A, A} >> amt);
        rot_l   = WIDTH'(({A, A} << amt) >> WIDTH);
        alu_lo  = A & B;
        alu_hi  = '0;
        alu_dbz = 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
        alu_carry = 1'b0;
`endif
        case (op)
            OP_ADD, OP_SUB: begin
                alu_lo = add_sum[WIDTH-1:0];
`ifdef SEQ_ALU_FLAGS_EN
                alu_carry = add_sum[WIDTH];
`endif
            end
            OP_SHR:  alu_lo = big ? '0 : A >> amt;
            OP_SHRA: alu_lo = big ? {WIDTH{A[WIDTH-1]}} : sra;
            OP_SHL:  alu_lo = big ? '0 : A << amt;
            OP_ROR:  alu_lo = rot_r;
            OP_ROL:  alu_lo = rot_l;
            OP_AND:  alu_lo = A & B;
            OP_OR:   alu_lo = A | B;
            OP_NEG:  alu_lo = -B;
            OP_NOT:  alu_lo = ~B;
            OP_DIV: begin
                alu_lo  = '1;
                alu_hi  = A;
                alu_dbz = 1'b1;
            end
            default: alu_lo = A & B;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_EXEC: state_d = accept ? (iter_op ? ST_ITER : ST_EXEC) : ST_IDLE;
            ST_ITER:          if (core_last) state_d = ST_FIX;
            ST_FIX:           state_d = ST_IDLE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        accept    = start && (state_q == ST_IDLE || state_q == ST_EXEC);
        iter_op   = (op == OP_MUL) || (op == OP_DIV && B != '0);
        core_load = accept && iter_op;
        core_step = (state_q == ST_ITER);
        busy      = (state_q == ST_ITER) || (state_q == ST_FIX);
        done      = done_q;
        result_hi = hi_q;
        result_lo = lo_q;
        div_by_zero = dbz_q;
`ifdef SEQ_ALU_FLAGS_EN
        zero     = zero_q;
        negative = neg_q;
        carry    = carry_q;
`endif
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        dbz_d  = dbz_q;
        done_d = 1'b0;
        if (state_q == ST_FIX) begin
            hi_d   = core_hi;
            lo_d   = core_lo;
            done_d = 1'b1;
        end else if (accept) begin
            dbz_d = iter_op ? 1'b0 : alu_dbz;
            if (!iter_op) begin
                hi_d   = alu_hi;
                lo_d   = alu_lo;
                done_d = 1'b1;
            end
        end
`ifdef SEQ_ALU_FLAGS_EN
        zero_d  = zero_q;
        neg_d   = neg_q;
        carry_d = carry_q;
        if (done_d) begin
            zero_d  = (lo_d == '0);
            neg_d   = lo_d[WIDTH-1];
            carry_d = (state_q == ST_FIX) ? 1'b0 : alu_carry;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
`endif
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
`ifdef SEQ_ALU_FLAGS_EN
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu with an expected-result queue popped on each done.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [4:0]   op = '0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] result_hi, result_lo;
`ifdef SEQ_ALU_FLAGS_EN
    logic         zero, negative, carry;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
        string        tag;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    seq_alu #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .result_hi   (result_hi),
        .result_lo   (result_lo),
`ifdef SEQ_ALU_FLAGS_EN
        .zero        (zero),
        .negative    (negative),
        .carry       (carry),
`endif
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // now=1 drives start in the current cycle (used for issue on a done cycle)
    task automatic issue(input bit now, input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz,
                         input int lat, input string tag);
        exp_t e;
        if (!now) @(negedge clock);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        e.hi = ehi; e.lo = elo; e.dbz = edbz; e.lat = lat; e.tag = tag;
        sb.push_back(e);
        @(posedge clock);
        #1;
        start = 1'b0;
        op    = 5'($urandom);
        A     = $urandom;
        B     = $urandom;
    endtask

    // Waits for done; poke_at>0 pulses a stray add start in that busy cycle
    task automatic wait_done(input int poke_at);
        exp_t e;
        bit   seen = 1'b0;
        e = sb.pop_front();
        for (int cyc = 1; cyc <= e.lat + 4 && !seen; cyc++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                chk({e.tag, " latency"}, 64'(cyc), 64'(e.lat));
                chk({e.tag, " lo"}, 64'(result_lo), 64'(e.lo));
                chk({e.tag, " hi"}, 64'(result_hi), 64'(e.hi));
                chk({e.tag, " dbz"}, 64'(div_by_zero), 64'(e.dbz));
                chk({e.tag, " busy_at_done"}, 64'(busy), 64'(0));
            end else begin
                if (e.lat > 1 && cyc < e.lat) chk({e.tag, " busy"}, 64'(busy), 64'(1));
                if (cyc == poke_at) begin
                    start = 1'b1; op = OP_ADD; A = 1; B = 1;
                end else if (cyc == poke_at + 1) begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk({e.tag, " done_seen"}, 64'(seen), 64'(1));
    endtask

    task automatic run(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz,
                       input int lat, input string tag);
        issue(1'b0, o, a, b, ehi, elo, edbz, lat, tag);
        wait_done(0);
    endtask

    initial begin
        logic signed [W-1:0]   sa, sb32;
        logic signed [2*W-1:0] sa64, sb64, p;
        logic signed [W-1:0]   q, r;
        logic [W-1:0]          ra, rb;

        repeat (3) @(negedge clock);
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst hi", 64'(result_hi), 64'(0));
        chk("rst lo", 64'(result_lo), 64'(0));
        chk("rst dbz", 64'(div_by_zero), 64'(0));
`ifdef SEQ_ALU_FLAGS_EN
        chk("rst flags", 64'({zero, negative, carry}), 64'(0));
`endif
        reset_n = 1'b1;

        run(OP_MUL, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, "mul -3*7");
        @(negedge clock);
        chk("done pulse", 64'(done), 64'(0));
        chk("hold lo", 64'(result_lo), 64'hFFFFFFEB);

        run(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, "div -7/2");
        run(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34, "div min/-1");
        run(OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1, "div 5/0");
        run(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd3, 1'b0, 1, "add clears dbz");

        run(OP_SHRA, 32'h80000000, 32'd40, 32'd0, 32'hFFFFFFFF, 1'b0, 1, "shra 40");
        run(OP_SHR,  32'h80000000, 32'd40, 32'd0, 32'h0, 1'b0, 1, "shr 40");
        run(OP_SHRA, 32'h80000000, 32'd4, 32'd0, 32'hF8000000, 1'b0, 1, "shra 4");
        run(OP_SHR,  32'h80000000, 32'd31, 32'd0, 32'h1, 1'b0, 1, "shr 31");
        run(OP_SHL,  32'h1, 32'd31, 32'd0, 32'h80000000, 1'b0, 1, "shl 31");
        run(OP_SHL,  32'h1, 32'd32, 32'd0, 32'h0, 1'b0, 1, "shl 32");
        run(OP_SHR,  32'h1234, 32'd0, 32'd0, 32'h1234, 1'b0, 1, "shr 0");
        run(OP_ROL,  32'h80000001, 32'd33, 32'd0, 32'h3, 1'b0, 1, "rol 33");
        run(OP_ROR,  32'h1, 32'd0, 32'd0, 32'h1, 1'b0, 1, "ror 0");
        run(OP_ROR,  32'h1, 32'd33, 32'd0, 32'h80000000, 1'b0, 1, "ror 33");
        run(OP_SUB,  32'd3, 32'd5, 32'd0, 32'hFFFFFFFE, 1'b0, 1, "sub 3-5");
        run(OP_ADD,  32'hFFFFFFFF, 32'd1, 32'd0, 32'h0, 1'b0, 1, "add wrap");
`ifdef SEQ_ALU_FLAGS_EN
        chk("flags add wrap", 64'({zero, negative, carry}), 64'(3'b101));
`endif
        run(OP_AND,  32'hF0F00000, 32'hFF00FF00, 32'd0, 32'hF0000000, 1'b0, 1, "and");
        run(OP_OR,   32'hF0F00000, 32'h0000000F, 32'd0, 32'hF0F0000F, 1'b0, 1, "or");
        run(OP_NEG,  32'd0, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b0, 1, "neg 1");
`ifdef SEQ_ALU_FLAGS_EN
        chk("flags neg", 64'({zero, negative, carry}), 64'(3'b010));
`endif
        run(OP_NOT,  32'd0, 32'h0F0F0F0F, 32'd0, 32'hF0F0F0F0, 1'b0, 1, "not");
        run(5'd20,   32'hC, 32'hA, 32'd0, 32'h8, 1'b0, 1, "unknown as and");

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            sa = ra; sb32 = rb; sa64 = sa; sb64 = sb32;
            p = sa64 * sb64;
            run(OP_MUL, ra, rb, p[2*W-1:W], p[W-1:0], 1'b0, 34, "mul rand");
            if (rb == '0) rb = 32'd3;
            if (i == 1) rb = rb >> 20;
            sb32 = rb;
            q = sa / sb32;
            r = sa % sb32;
            run(OP_DIV, ra, rb, r, q, 1'b0, 34, "div rand");
        end

        issue(1'b0, OP_MUL, 32'd5, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFE2, 1'b0, 34, "mul stray start");
        wait_done(5);
        @(negedge clock);
        chk("stray no extra done", 64'(done), 64'(0));

        issue(1'b0, OP_MUL, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 34, "aborted mul");
        sb.delete();
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort done", 64'(done), 64'(0));
        chk("abort hi", 64'(result_hi), 64'(0));
        chk("abort lo", 64'(result_lo), 64'(0));
        chk("abort dbz", 64'(div_by_zero), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;
        repeat (30) @(negedge clock);
        chk("abort no done", 64'(done), 64'(0));
        chk("abort no result", 64'(result_lo), 64'(0));
        run(OP_MUL, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 34, "mul after abort");

        issue(1'b0, OP_ADD, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0, 1, "b2b add");
        wait_done(0);
        issue(1'b1, OP_MUL, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFCF, 1'b0, 34, "b2b mul");
        wait_done(0);
        issue(1'b1, OP_SUB, 32'd10, 32'd4, 32'd0, 32'd6, 1'b0, 1, "b2b after mul");
        wait_done(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
